// File: rtl/blueberry_pkg.sv
// Shared definitions for the 10-bit bus ALU control path: opcodes, sequencer
// states, bus source selects and the decoded instruction record.
package blueberry_pkg;

  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_INV = 4'b0100;
  localparam logic [3:0] OP_FLP = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_REG  = 2'b01;
  localparam logic [1:0] BUS_EXT  = 2'b10;
  localparam logic [1:0] BUS_ALU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_MOV  = 3'd5,
    S_IMM  = 3'd6,
    S_ERRS = 3'd7
  } seq_state_t;

  // IR[1:0] is reserved, so only the opcode and register fields are kept.
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
  } instr_t;

  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_INV) || (op == OP_FLP);
  endfunction

  function automatic seq_state_t first_state(input logic [3:0] op, input logic skip_a_unary);
    if (op == OP_LD)                    return S_MOV;
    else if (op == OP_LDI)              return S_IMM;
    else if (op > OP_ASR)               return S_ERRS;
    else if (skip_a_unary && is_unary(op)) return S_LDB;
    else                                return S_LDA;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus datapath control bundle between the sequencer
// (master) and the instruction source / datapath side (slave).
interface alu_sequencer_if #(parameter int NREG = 4);
  logic [9:0]      IR;
  logic            IR_VALID;
  logic            IR_READY;
  logic [3:0]      FN;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic [1:0]      BUS_SEL;
  logic            DONE;
  logic            ERR;
  logic [2:0]      STEP;

  modport master (
    input  IR, IR_VALID,
    output IR_READY, FN, Ain, Gin, Gout, Rout, Rin, BUS_SEL, DONE, ERR, STEP
  );

  modport slave (
    output IR, IR_VALID,
    input  IR_READY, FN, Ain, Gin, Gout, Rout, Rin, BUS_SEL, DONE, ERR, STEP
  );
endinterface

// File: rtl/alu_sequencer_onehot_dec2.sv
// 2-bit register field to 4-bit one-hot select.
module onehot_dec2 (
  input  logic [1:0] sel,
  output logic [3:0] onehot
);
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the 10-bit bus ALU: one instruction per
// handshake, stepped through register/ALU bus transfers.
module alu_sequencer
  import blueberry_pkg::*;
#(
  parameter int NREG         = 4,
  parameter bit SKIP_A_UNARY = 1'b1
) (
  input  logic           CLKb,
  input  logic           RST,
  alu_sequencer_if.master bus
);

  seq_state_t state_q, state_d;
  instr_t     ir_q, ir_d;

  logic [NREG-1:0] rx_oh, ry_oh;
  logic            unused_rsvd;

  assign unused_rsvd = ^bus.IR[1:0];

  onehot_dec2 u_dec_rx (.sel(ir_q.rx), .onehot(rx_oh));
  onehot_dec2 u_dec_ry (.sel(ir_q.ry), .onehot(ry_oh));

  always_ff @(posedge CLKb) begin
    if (RST) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.IR_VALID) begin
          ir_d    = bus.IR[9:2];
          state_d = first_state(bus.IR[9:6], SKIP_A_UNARY);
        end
      end
      S_LDA:   state_d = S_LDB;
      S_LDB:   state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on the registered state and latched instruction.
  always_comb begin
    bus.IR_READY = 1'b0;
    bus.FN       = '0;
    bus.Ain      = 1'b0;
    bus.Gin      = 1'b0;
    bus.Gout     = 1'b0;
    bus.Rout     = '0;
    bus.Rin      = '0;
    bus.BUS_SEL  = BUS_NONE;
    bus.DONE     = 1'b0;
    bus.ERR      = 1'b0;
    bus.STEP     = state_q;
    unique case (state_q)
      S_IDLE: bus.IR_READY = 1'b1;
      S_LDA: begin
        bus.Rout    = rx_oh;
        bus.BUS_SEL = BUS_REG;
        bus.Ain     = 1'b1;
      end
      S_LDB: begin
        bus.Rout    = ry_oh;
        bus.BUS_SEL = BUS_REG;
        bus.Gin     = 1'b1;
      end
      S_EXEC: begin
        bus.FN   = ir_q.op;
        bus.Gout = 1'b1;
      end
      S_WB: begin
        bus.BUS_SEL = BUS_ALU;
        bus.Rin     = rx_oh;
        bus.DONE    = 1'b1;
      end
      S_MOV: begin
        bus.Rout    = ry_oh;
        bus.BUS_SEL = BUS_REG;
        bus.Rin     = rx_oh;
        bus.DONE    = 1'b1;
      end
      S_IMM: begin
        bus.BUS_SEL = BUS_EXT;
        bus.Rin     = rx_oh;
        bus.DONE    = 1'b1;
      end
      S_ERRS: begin
        bus.ERR  = 1'b1;
        bus.DONE = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed table-driven bench for alu_sequencer, plus a second instance with
// the unary A-load skip disabled.
module tb_alu_sequencer;

  typedef struct packed {
    logic       ready;
    logic [3:0] fn;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] rout;
    logic [3:0] rin;
    logic [1:0] bsel;
    logic       done;
    logic       err;
    logic [2:0] step;
  } out_t;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [9:0] ir;
    out_t       exp;
  } vec_t;

  logic CLKb = 1'b0;
  logic RST  = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  always #5 CLKb = ~CLKb;

  alu_sequencer_if #(.NREG(4)) bus1 ();
  alu_sequencer_if #(.NREG(4)) bus2 ();

  alu_sequencer #(.NREG(4), .SKIP_A_UNARY(1'b1)) dut1 (.CLKb(CLKb), .RST(RST), .bus(bus1));
  alu_sequencer #(.NREG(4), .SKIP_A_UNARY(1'b0)) dut2 (.CLKb(CLKb), .RST(RST), .bus(bus2));

  function automatic out_t o(input logic rd, input logic [3:0] fn, input logic ain,
                             input logic gin, input logic gout, input logic [3:0] rout,
                             input logic [3:0] rin, input logic [1:0] bs, input logic dn,
                             input logic er, input logic [2:0] st);
    o = '{rd, fn, ain, gin, gout, rout, rin, bs, dn, er, st};
  endfunction

  function automatic out_t get1();
    get1 = '{bus1.IR_READY, bus1.FN, bus1.Ain, bus1.Gin, bus1.Gout, bus1.Rout,
             bus1.Rin, bus1.BUS_SEL, bus1.DONE, bus1.ERR, bus1.STEP};
  endfunction

  function automatic out_t get2();
    get2 = '{bus2.IR_READY, bus2.FN, bus2.Ain, bus2.Gin, bus2.Gout, bus2.Rout,
             bus2.Rin, bus2.BUS_SEL, bus2.DONE, bus2.ERR, bus2.STEP};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Structural output rules, checked every cycle once reset has settled.
  always @(negedge CLKb) begin
    if (mon_en) begin
      checks += 3;
      if (bus1.FN != 4'b0000 && bus1.STEP != 3'd3) begin
        failures++;
        $display("FAIL fn_outside_exec: FN=%b STEP=%0d required FN=0000", bus1.FN, bus1.STEP);
      end
      if (!$onehot0({bus1.Ain, bus1.Gin, bus1.Gout})) begin
        failures++;
        $display("FAIL ctl_exclusive: Ain/Gin/Gout=%b required at most one", {bus1.Ain, bus1.Gin, bus1.Gout});
      end
      if (!$onehot0(bus1.Rout) || !$onehot0(bus1.Rin)) begin
        failures++;
        $display("FAIL reg_onehot: Rout=%b Rin=%b required at most one bit each", bus1.Rout, bus1.Rin);
      end
    end
  end

  vec_t vecs[$];

  initial begin
    bus1.IR = '0; bus1.IR_VALID = 1'b0;
    bus2.IR = '0; bus2.IR_VALID = 1'b0;

    //          rdy fn      ain  gin  gout rout     rin      bs     dn   er   step
    vecs.push_back('{1, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)}); // reset
    vecs.push_back('{0, 1, 10'b0010011000, o(0, 4'h0, 1, 0, 0, 4'b0010, 4'b0000, 2'b01, 0, 0, 3'd1)}); // add R1,R2: LDA
    vecs.push_back('{0, 0, 10'b1111111111, o(0, 4'h0, 0, 1, 0, 4'b0100, 4'b0000, 2'b01, 0, 0, 3'd2)}); // IR noise ignored
    vecs.push_back('{0, 0, 10'b0000000000, o(0, 4'h2, 0, 0, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd3)});
    vecs.push_back('{0, 0, 10'b0000000000, o(0, 4'h0, 0, 0, 0, 4'b0000, 4'b0010, 2'b11, 1, 0, 3'd4)});
    vecs.push_back('{0, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)});
    vecs.push_back('{0, 1, 10'b0101001100, o(0, 4'h0, 0, 1, 0, 4'b1000, 4'b0000, 2'b01, 0, 0, 3'd2)}); // flp R3: LDB
    vecs.push_back('{0, 0, 10'b0000000000, o(0, 4'h5, 0, 0, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd3)});
    vecs.push_back('{0, 0, 10'b0000000000, o(0, 4'h0, 0, 0, 0, 4'b0000, 4'b0001, 2'b11, 1, 0, 3'd4)});
    vecs.push_back('{0, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)});
    vecs.push_back('{0, 1, 10'b0001100000, o(0, 4'h0, 0, 0, 0, 4'b0000, 4'b0100, 2'b10, 1, 0, 3'd6)}); // ldi R2
    vecs.push_back('{0, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)});
    vecs.push_back('{0, 1, 10'b0000110100, o(0, 4'h0, 0, 0, 0, 4'b0010, 4'b1000, 2'b01, 1, 0, 3'd5)}); // ld R3,R1
    vecs.push_back('{0, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)});
    vecs.push_back('{0, 1, 10'b1110000000, o(0, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 1, 1, 3'd7)}); // illegal
    vecs.push_back('{0, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)});
    vecs.push_back('{0, 1, 10'b0011100100, o(0, 4'h0, 1, 0, 0, 4'b0100, 4'b0000, 2'b01, 0, 0, 3'd1)}); // sub R2,R1
    vecs.push_back('{0, 0, 10'b0000000000, o(0, 4'h0, 0, 1, 0, 4'b0010, 4'b0000, 2'b01, 0, 0, 3'd2)});
    vecs.push_back('{0, 0, 10'b0000000000, o(0, 4'h3, 0, 0, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd3)});
    vecs.push_back('{1, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)}); // reset in EXEC
    vecs.push_back('{0, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)}); // no WB
    vecs.push_back('{0, 1, 10'b0010110000, o(0, 4'h0, 1, 0, 0, 4'b1000, 4'b0000, 2'b01, 0, 0, 3'd1)}); // add R3,R0
    vecs.push_back('{0, 1, 10'b0000000100, o(0, 4'h0, 0, 1, 0, 4'b0001, 4'b0000, 2'b01, 0, 0, 3'd2)}); // 2nd held
    vecs.push_back('{0, 1, 10'b0000000100, o(0, 4'h2, 0, 0, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd3)});
    vecs.push_back('{0, 1, 10'b0000000100, o(0, 4'h0, 0, 0, 0, 4'b0000, 4'b1000, 2'b11, 1, 0, 3'd4)});
    vecs.push_back('{0, 1, 10'b0000000100, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)});
    vecs.push_back('{0, 1, 10'b0000000100, o(0, 4'h0, 0, 0, 0, 4'b0010, 4'b0001, 2'b01, 1, 0, 3'd5)}); // ld R0,R1
    vecs.push_back('{0, 0, 10'b0000000000, o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0)});

    foreach (vecs[i]) begin
      RST           = vecs[i].rst;
      bus1.IR_VALID = vecs[i].valid;
      bus1.IR       = vecs[i].ir;
      @(posedge CLKb);
      @(negedge CLKb);
      check($sformatf("vec%0d", i), get1(), vecs[i].exp);
      mon_en = 1'b1;
    end

    // Second instance: unary ops take the full LDA path; opcode boundaries.
    check("dut2_idle", get2(), o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0));
    bus2.IR_VALID = 1'b1; bus2.IR = 10'b0100011000;  // inv R1 (B=R2)
    @(posedge CLKb); @(negedge CLKb);
    bus2.IR_VALID = 1'b0;
    check("inv_lda", get2(), o(0, 4'h0, 1, 0, 0, 4'b0010, 4'b0000, 2'b01, 0, 0, 3'd1));
    @(posedge CLKb); @(negedge CLKb);
    check("inv_ldb", get2(), o(0, 4'h0, 0, 1, 0, 4'b0100, 4'b0000, 2'b01, 0, 0, 3'd2));
    @(posedge CLKb); @(negedge CLKb);
    check("inv_exec", get2(), o(0, 4'h4, 0, 0, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd3));
    @(posedge CLKb); @(negedge CLKb);
    check("inv_wb", get2(), o(0, 4'h0, 0, 0, 0, 4'b0000, 4'b0010, 2'b11, 1, 0, 3'd4));
    @(posedge CLKb); @(negedge CLKb);
    bus2.IR_VALID = 1'b1; bus2.IR = 10'b1011000000;  // asr, last legal opcode
    @(posedge CLKb); @(negedge CLKb);
    bus2.IR_VALID = 1'b0;
    check("asr_lda", get2(), o(0, 4'h0, 1, 0, 0, 4'b0001, 4'b0000, 2'b01, 0, 0, 3'd1));
    repeat (3) @(posedge CLKb);
    @(posedge CLKb); @(negedge CLKb);
    check("asr_idle", get2(), o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0));
    bus2.IR_VALID = 1'b1; bus2.IR = 10'b1100111100;  // first illegal opcode
    @(posedge CLKb); @(negedge CLKb);
    bus2.IR_VALID = 1'b0;
    check("op1100_err", get2(), o(0, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 1, 1, 3'd7));
    @(posedge CLKb); @(negedge CLKb);
    check("op1100_idle", get2(), o(1, 4'h0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
